pipe_ctrl_unit: RTL and testbench

//  Pipelined LEGv8 control unit: decodes instr in ID, registers the control bundle into an EX-stage

---
 rtl/pipe_ctrl_unit_pkg.sv | 67 ++++++
 rtl/pipe_ctrl_unit_if.sv | 47 ++++
 rtl/pipe_ctrl_unit_decode.sv | 54 +++++
 rtl/pipe_ctrl_unit.sv | 93 +++++++++
 tb/tb_pipe_ctrl_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipelined LEGv8 control unit.
//   - opcode prefixes for every decoded instruction class
//   - B.cond condition-code values
//   - ALU operation enum and the control bundle carried from ID into EX
//   - cond_hit(): evaluates a B.cond condition against NZCV
package pipe_ctrl_unit_pkg;

    // Full 11-bit opcodes (instr[31:21])
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    // Shorter prefixes: remaining opcode bits belong to the immediate
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;   // instr[31:22]
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;   // instr[31:22]
    localparam logic [5:0]  OP_B     = 6'b000101;        // instr[31:26]
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;      // instr[31:24]
    localparam logic [7:0]  OP_BCOND = 8'b01010100;      // instr[31:24]

    // B.cond condition codes (instr[3:0]); anything else is never taken
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011
    } aluop_e;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       alusrc1;
        logic       memtoreg;
        logic       regwri;
        logic       memwri;
        logic       readmem;
        logic       setf;
        logic       is_b;
        logic       is_cbz;
        logic       is_bcond;
        logic       illegal;
        aluop_e     aluop;
        logic [3:0] cond;
        logic [4:0] rd;
    } ctrl_t;

    function automatic logic cond_hit(input logic [3:0] cond,
                                      input logic n, input logic z, input logic v);
        case (cond)
            COND_EQ: cond_hit = z;
            COND_NE: cond_hit = ~z;
            COND_GE: cond_hit = (n == v);
            COND_LT: cond_hit = (n != v);
            COND_GT: cond_hit = ~z & (n == v);
            COND_LE: cond_hit = z | (n != v);
            COND_AL: cond_hit = 1'b1;
            default: cond_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Fetch-side and EX-side signal bundle of the control unit.
//   fetch : in_valid, instr -> in_ready
//   EX    : ex_ready, alu_zero, alu_flags -> out_valid, datapath controls,
//           out_rd, branch resolution, flush, illegal, flags_q, perf counters
// slave modport = the control unit, master modport = its environment.
interface pipe_ctrl_unit_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic               ex_ready;
    logic               alu_zero;
    logic [3:0]         alu_flags;
    logic               out_valid;
    logic               reg2loc;
    logic               alusrc;
    logic               alusrc1;
    logic               memtoreg;
    logic               regwri;
    logic               memwri;
    logic               readmem;
    logic [ALUOP_W-1:0] aluop;
    logic [4:0]         out_rd;
    logic               br_taken;
    logic               uncond_br;
    logic               flush;
    logic               illegal;
    logic [3:0]         flags_q;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport slave (
        input  in_valid, instr, ex_ready, alu_zero, alu_flags,
        output in_ready, out_valid, reg2loc, alusrc, alusrc1, memtoreg, regwri,
               memwri, readmem, aluop, out_rd, br_taken, uncond_br, flush,
               illegal, flags_q, stall_cnt, flush_cnt
    );

    modport master (
        output in_valid, instr, ex_ready, alu_zero, alu_flags,
        input  in_ready, out_valid, reg2loc, alusrc, alusrc1, memtoreg, regwri,
               memwri, readmem, aluop, out_rd, br_taken, uncond_br, flush,
               illegal, flags_q, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational LEGv8 decoder: instruction word -> control bundle.
//   instr : instruction word in ID
//   ctrl  : decoded control bundle; every field not meaningful for the
//           instruction class is 0, unknown opcodes raise illegal only.
module pipe_ctrl_unit_decode
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int HAS_BCOND = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    // Operand/immediate fields are not needed to pick the controls.
    logic unused_fields;
    assign unused_fields = ^instr[20:5];

    always_comb begin
        ctrl    = '0;
        ctrl.rd = instr[4:0];
        if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS) begin
            ctrl.regwri = 1'b1;
            ctrl.setf   = 1'b1;
            ctrl.aluop  = (instr[31:21] == OP_ADDS) ? ALU_ADD : ALU_SUB;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            ctrl.regwri  = 1'b1;
            ctrl.alusrc1 = 1'b1;
            ctrl.aluop   = (instr[31:22] == OP_ADDI) ? ALU_ADD : ALU_SUB;
        end else if (instr[31:21] == OP_LDUR) begin
            ctrl.alusrc   = 1'b1;
            ctrl.readmem  = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.regwri   = 1'b1;
            ctrl.aluop    = ALU_ADD;
        end else if (instr[31:21] == OP_STUR) begin
            ctrl.alusrc  = 1'b1;
            ctrl.memwri  = 1'b1;
            ctrl.reg2loc = 1'b1;
            ctrl.aluop   = ALU_ADD;
        end else if (instr[31:26] == OP_B) begin
            ctrl.is_b = 1'b1;
        end else if (instr[31:24] == OP_CBZ) begin
            // CBZ tests Rt, so the second read port must select instr[4:0]
            ctrl.is_cbz  = 1'b1;
            ctrl.reg2loc = 1'b1;
        end else if (HAS_BCOND != 0 && instr[31:24] == OP_BCOND) begin
            ctrl.is_bcond = 1'b1;
            ctrl.cond     = instr[3:0];
        end else begin
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined LEGv8 control unit.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of pipe_ctrl_unit_if (fetch handshake in,
//                EX control bundle, branch resolution, flags, counters out)
// Decodes the ID instruction, registers its controls into the EX register,
// resolves branches in EX, keeps NZCV, inserts load-use bubbles and drops
// the ID instruction on a taken branch.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int ALUOP_W   = 3,
    parameter int HAS_BCOND = 1,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_ctrl_unit_if.slave bus
);

    ctrl_t            dec;
    ctrl_t            ex_reg;
    logic             out_valid_reg;
    logic [3:0]       flags_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic hazard, stall, flush, adv, br_taken, load_real;

    pipe_ctrl_unit_decode #(.HAS_BCOND(HAS_BCOND)) u_decode (
        .instr (bus.instr),
        .ctrl  (dec)
    );

    always_comb begin
        // Rn is compared for every ID instruction (conservative: may stall a
        // branch needlessly, never misses a real dependency).
        hazard = out_valid_reg & ex_reg.readmem & (ex_reg.rd != 5'd31) & bus.in_valid &
                 ((ex_reg.rd == bus.instr[9:5]) |
                  (dec.setf & (ex_reg.rd == bus.instr[20:16])) |
                  ((dec.memwri | dec.is_cbz) & (ex_reg.rd == bus.instr[4:0])));
        br_taken = out_valid_reg &
                   (ex_reg.is_b |
                    (ex_reg.is_cbz & bus.alu_zero) |
                    (ex_reg.is_bcond & cond_hit(ex_reg.cond, flags_reg[3], flags_reg[2], flags_reg[0])));
        flush     = out_valid_reg & br_taken & bus.ex_ready;
        adv       = ~out_valid_reg | bus.ex_ready;
        stall     = hazard & ~flush;   // a flush overrides any stall
        load_real = adv & bus.in_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg        <= '0;
            out_valid_reg <= 1'b0;
            flags_reg     <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (adv) begin
                ex_reg        <= load_real ? dec : '0;
                out_valid_reg <= load_real;
            end
            // Flags commit when the setting instruction leaves EX, so the
            // instruction right behind it already sees them.
            if (out_valid_reg && ex_reg.setf && bus.ex_ready)
                flags_reg <= bus.alu_flags;
            if (stall && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.in_ready  = (~stall & adv) | flush;
    assign bus.out_valid = out_valid_reg;
    assign bus.reg2loc   = ex_reg.reg2loc;
    assign bus.alusrc    = ex_reg.alusrc;
    assign bus.alusrc1   = ex_reg.alusrc1;
    assign bus.memtoreg  = ex_reg.memtoreg;
    assign bus.regwri    = ex_reg.regwri;
    assign bus.memwri    = ex_reg.memwri;
    assign bus.readmem   = ex_reg.readmem;
    assign bus.aluop     = ALUOP_W'(ex_reg.aluop);
    assign bus.out_rd    = ex_reg.rd;
    assign bus.br_taken  = br_taken;
    assign bus.uncond_br = ex_reg.is_b;
    assign bus.flush     = flush;
    assign bus.illegal   = ex_reg.illegal;
    assign bus.flags_q   = flags_reg;
    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed steps followed by
// random traffic, all checked against an instruction-level reference model.
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.ALUOP_W(3), .CNT_W(16)) bus ();

    pipe_ctrl_unit #(.ALUOP_W(3), .HAS_BCOND(1), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    localparam int K_NONE = 0, K_ADDS = 1, K_SUBS = 2, K_ADDI = 3, K_SUBI = 4, K_LDUR = 5,
                   K_STUR = 6, K_B = 7, K_CBZ = 8, K_BCOND = 9, K_ILL = 10;

    // Reference model: what instruction sits in EX, plus architectural state
    bit          m_valid, n_valid;
    logic [31:0] m_instr, n_instr;
    logic [3:0]  m_flags, n_flags;
    int          m_stall, n_stall, m_flush, n_flush;

    function automatic int kind_of(input logic [31:0] i);
        logic [10:0] op;
        op = i[31:21];
        if (op == 11'b10101011000)  return K_ADDS;
        if (op == 11'b11101011000)  return K_SUBS;
        if (op ==? 11'b1001000100?) return K_ADDI;
        if (op ==? 11'b1101000100?) return K_SUBI;
        if (op == 11'b11111000010)  return K_LDUR;
        if (op == 11'b11111000000)  return K_STUR;
        if (op ==? 11'b000101?????) return K_B;
        if (op ==? 11'b10110100???) return K_CBZ;
        if (op ==? 11'b01010100???) return K_BCOND;
        return K_ILL;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {reg2loc, alusrc, alusrc1, memtoreg, regwri, memwri, readmem}
    function automatic logic [6:0] ctl_of(input int k);
        case (k)
            K_ADDS, K_SUBS: return 7'b0000100;
            K_ADDI, K_SUBI: return 7'b0010100;
            K_LDUR:         return 7'b0101101;
            K_STUR:         return 7'b1100010;
            K_CBZ:          return 7'b1000000;
            default:        return 7'b0000000;
        endcase
    endfunction

    function automatic logic [2:0] aluop_of(input int k);
        case (k)
            K_ADDS, K_ADDI, K_LDUR, K_STUR: return 3'b010;
            K_SUBS, K_SUBI:                 return 3'b011;
            default:                        return 3'b000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then compute the model's next state.
    task automatic check_now();
        int ek, ik;
        bit br, fl, hz, st, adv;
        logic [4:0] rd;
        ek = m_valid ? kind_of(m_instr) : K_NONE;
        ik = kind_of(bus.instr);
        rd = m_instr[4:0];
        br = m_valid && (ek == K_B || (ek == K_CBZ && bus.alu_zero) ||
                         (ek == K_BCOND && cond_ok(m_instr[3:0], m_flags)));
        fl = br && bus.ex_ready;
        hz = m_valid && ek == K_LDUR && rd != 5'd31 && bus.in_valid &&
             (rd == bus.instr[9:5] ||
              ((ik == K_ADDS || ik == K_SUBS) && rd == bus.instr[20:16]) ||
              ((ik == K_STUR || ik == K_CBZ) && rd == bus.instr[4:0]));
        st  = hz && !fl;
        adv = !m_valid || bus.ex_ready;

        chk("out_valid", bus.out_valid, m_valid);
        chk("controls", {bus.reg2loc, bus.alusrc, bus.alusrc1, bus.memtoreg,
                         bus.regwri, bus.memwri, bus.readmem}, ctl_of(ek));
        chk("aluop", bus.aluop, aluop_of(ek));
        chk("out_rd", bus.out_rd, m_valid ? rd : 5'd0);
        chk("illegal", bus.illegal, ek == K_ILL);
        chk("uncond_br", bus.uncond_br, ek == K_B);
        chk("br_taken", bus.br_taken, br);
        chk("flush", bus.flush, fl);
        chk("in_ready", bus.in_ready, (!st && adv) || fl);
        chk("flags_q", bus.flags_q, m_flags);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("flush_cnt", bus.flush_cnt, m_flush);

        n_valid = m_valid;
        n_instr = m_instr;
        if (adv) begin
            n_valid = bus.in_valid && !st && !fl;
            n_instr = bus.instr;
        end
        n_flags = m_flags;
        if (m_valid && (ek == K_ADDS || ek == K_SUBS) && bus.ex_ready) n_flags = bus.alu_flags;
        n_stall = (st && m_stall < 65535) ? m_stall + 1 : m_stall;
        n_flush = (fl && m_flush < 65535) ? m_flush + 1 : m_flush;
    endtask

    task automatic step(input bit iv, input logic [31:0] ins, input bit er,
                        input bit az, input logic [3:0] af);
        @(posedge clk);
        m_valid = n_valid; m_instr = n_instr; m_flags = n_flags;
        m_stall = n_stall; m_flush = n_flush;
        @(negedge clk);
        bus.in_valid = iv; bus.instr = ins; bus.ex_ready = er;
        bus.alu_zero = az; bus.alu_flags = af;
        #1;
        check_now();
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
        chk("rst_flush_cnt", bus.flush_cnt, 16'd0);
        chk("rst_flags_q", bus.flags_q, 4'd0);
        chk("rst_out_rd", bus.out_rd, 5'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        m_valid = 0; m_instr = '0; m_flags = '0; m_stall = 0; m_flush = 0;
        #1;
        check_now();
    endtask

    function automatic logic [4:0] rreg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 9))
            0: return {11'b10101011000, rreg(), 6'd0, rreg(), rreg()};
            1: return {11'b11101011000, rreg(), 6'd0, rreg(), rreg()};
            2: return {10'b1001000100, 12'($urandom), rreg(), rreg()};
            3: return {10'b1101000100, 12'($urandom), rreg(), rreg()};
            4: return {11'b11111000010, 9'($urandom), 2'b00, rreg(), rreg()};
            5: return {11'b11111000000, 9'($urandom), 2'b00, rreg(), rreg()};
            6: return {6'b000101, 26'($urandom)};
            7: return {8'b10110100, 19'($urandom), rreg()};
            8: return {8'b01010100, 19'($urandom), 1'b0, 4'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] I_ADDI = {10'b1001000100, 12'd5, 5'd1, 5'd1};     // ADDI X1,X1,#5
    localparam logic [31:0] I_SUBS = {11'b11101011000, 5'd3, 6'd0, 5'd1, 5'd2}; // SUBS X2,X1,X3
    localparam logic [31:0] I_NOPI = {10'b1001000100, 12'd0, 5'd9, 5'd9};     // ADDI X9,X9,#0
    localparam logic [31:0] I_BLT  = {8'b01010100, 19'd4, 1'b0, 4'hB};
    localparam logic [31:0] I_BGE  = {8'b01010100, 19'd4, 1'b0, 4'hA};
    localparam logic [31:0] I_LDUR = {11'b11111000010, 9'd0, 2'b00, 5'd5, 5'd4}; // LDUR X4,[X5]
    localparam logic [31:0] I_ADDS = {11'b10101011000, 5'd7, 6'd0, 5'd4, 5'd6};  // ADDS X6,X4,X7
    localparam logic [31:0] I_CBZ  = {8'b10110100, 19'd8, 5'd0};                 // CBZ X0
    localparam logic [31:0] I_STUR = {11'b11111000000, 9'd0, 2'b00, 5'd2, 5'd1}; // STUR X1,[X2]
    localparam logic [31:0] I_ADS1 = {11'b10101011000, 5'd7, 6'd0, 5'd1, 5'd6};  // ADDS X6,X1,X7

    initial begin
        bus.in_valid = 1'b0; bus.instr = '0; bus.ex_ready = 1'b1;
        bus.alu_zero = 1'b0; bus.alu_flags = '0;
        reset_seq();

        // Back-to-back ALU ops, then SUBS flags feeding B.LT / B.GE
        step(1, I_ADDI, 1, 0, 4'h0);
        step(1, I_SUBS, 1, 0, 4'h0);
        chk("addi_valid", bus.out_valid, 1'b1);
        chk("addi_aluop", bus.aluop, 3'b010);
        step(1, I_BLT, 1, 0, 4'b1000);
        chk("subs_valid", bus.out_valid, 1'b1);
        chk("subs_aluop", bus.aluop, 3'b011);
        step(1, I_NOPI, 1, 0, 4'h0);
        chk("blt_flags", bus.flags_q, 4'b1000);
        chk("blt_taken", bus.br_taken, 1'b1);
        chk("blt_flush", bus.flush, 1'b1);
        step(1, I_NOPI, 1, 0, 4'h0);
        chk("post_flush_bubble", bus.out_valid, 1'b0);
        step(1, I_BGE, 1, 0, 4'h0);
        step(1, I_NOPI, 1, 0, 4'h0);
        chk("bge_taken", bus.br_taken, 1'b0);

        // Load-use stall with fresh counters
        reset_seq();
        step(1, I_LDUR, 1, 0, 4'h0);
        step(1, I_ADDS, 1, 0, 4'h0);
        chk("ldu_in_ready", bus.in_ready, 1'b0);
        step(1, I_ADDS, 1, 0, 4'h0);
        chk("ldu_bubble", bus.out_valid, 1'b0);
        chk("ldu_stall_cnt", bus.stall_cnt, 16'd1);

        // CBZ taken / not taken
        step(1, I_CBZ, 1, 0, 4'h0);
        step(1, I_NOPI, 1, 1, 4'h0);
        chk("cbz_taken", bus.br_taken, 1'b1);
        chk("cbz_uncond", bus.uncond_br, 1'b0);
        chk("cbz_flush", bus.flush, 1'b1);
        step(1, I_NOPI, 1, 0, 4'h0);
        chk("cbz_bubble", bus.out_valid, 1'b0);
        chk("cbz_flush_cnt", bus.flush_cnt, 16'd1);
        step(1, I_CBZ, 1, 0, 4'h0);
        step(1, I_NOPI, 1, 0, 4'h0);
        chk("cbz_nt_flush", bus.flush, 1'b0);

        // STUR held in EX for three cycles
        step(1, I_STUR, 1, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, I_ADS1, 0, 0, 4'b1111);
            chk("hold_memwri", bus.memwri, 1'b1);
            chk("hold_rd", bus.out_rd, 5'd1);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_flags", bus.flags_q, 4'b0000);
        end
        step(1, I_NOPI, 1, 0, 4'h0);

        // Unknown opcode
        step(1, 32'h0000_0000, 1, 0, 4'h0);
        step(1, I_NOPI, 1, 0, 4'h0);
        chk("illegal", bus.illegal, 1'b1);
        chk("illegal_regwri", bus.regwri, 1'b0);

        // Random traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #2;
                reset_seq();
            end
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 3) != 0,
                 1'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
